// File: rtl/fixed_exp_pkg.sv
// fixed_exp_pkg: shared types, width derivations and helpers for fixed_exp_seq.
// Optional build macro FIXED_EXP_EARLY_EXIT_EN is consumed by fixed_exp_seq.
package fixed_exp_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_SAT,
        S_DONE
    } state_e;

    typedef struct packed {
        logic        sat;
        logic [63:0] y;
    } rs_t;

    function automatic int acc_frac_f(input int out_frac, input int guard);
        return out_frac + guard;
    endfunction

    // Integer bits: largest (2^IN_INT)^k/k! over the series, or the output range.
    function automatic int acc_int_f(input int in_int, input int out_int,
                                     input int n_terms);
        longint p;
        longint mx;
        int     b;
        p  = longint'(1) << 16;
        mx = p;
        for (int k = 1; k < n_terms; k++) begin
            p = (p << in_int) / longint'(k);
            if (p > mx) mx = p;
        end
        b = $clog2((mx >>> 16) + 1);
        return ((b > out_int) ? b : out_int) + 1;
    endfunction

    // 1/k rounded to nearest, acc_frac fraction bits.
    function automatic longint recip_f(input int k, input int acc_frac);
        if (k < 1) return 0;
        return ((longint'(1) << acc_frac) + longint'(k / 2)) / longint'(k);
    endfunction

    function automatic rs_t round_sat_f(input longint sum, input int guard,
                                        input int out_w);
        rs_t    r;
        longint rnd;
        longint mx;
        r  = '0;
        mx = (longint'(1) << out_w) - 1;
        if (guard > 0) rnd = (sum + (longint'(1) <<< (guard - 1))) >>> guard;
        else           rnd = sum;
        if (sum < 0) begin
            r.y = '0;
        end else if (rnd > mx) begin
            r.y   = 64'(mx);
            r.sat = 1'b1;
        end else begin
            r.y = 64'(rnd);
        end
        return r;
    endfunction

endpackage

// File: rtl/fixed_exp_round_sat.sv
// fixed_exp_round_sat: half-up rounding of the series sum to the output
// format, clamping negatives to zero and overflow to all-ones.
module fixed_exp_round_sat
    import fixed_exp_pkg::*;
#(
    parameter int ACC_W = 20,
    parameter int GUARD = 8,
    parameter int OUT_W = 10
) (
    input  logic signed [ACC_W-1:0] sum_i,
    output logic        [OUT_W-1:0] y_o,
    output logic                    sat_o
);

    rs_t  r;
    logic unused;

    assign r      = round_sat_f(64'(sum_i), GUARD, OUT_W);
    assign y_o    = r.y[OUT_W-1:0];
    assign sat_o  = r.sat;
    assign unused = ^r.y[63:OUT_W];

endmodule

// File: rtl/fixed_exp_seq.sv
// fixed_exp_seq: sequential Taylor-series exp(x), one term per clock.
// Define FIXED_EXP_EARLY_EXIT_EN to stop once the running term reaches zero.
module fixed_exp_seq
    import fixed_exp_pkg::*;
#(
    parameter int IN_INT     = 2,
    parameter int IN_FRAC    = 7,
    parameter int OUT_INT    = 5,
    parameter int OUT_FRAC   = 5,
    parameter int GUARD      = 8,
    parameter int N_TERMS    = 20,
    parameter int SAT_X_CODE = 444
) (
    input  logic                         CLOCK_50,
    input  logic                         RESET_N,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_INT+IN_FRAC:0]      in_x,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_INT+OUT_FRAC-1:0]  out_y,
    output logic                         out_sat
);

    localparam int IN_W     = 1 + IN_INT + IN_FRAC;
    localparam int OUT_W    = OUT_INT + OUT_FRAC;
    localparam int ACC_FRAC = acc_frac_f(OUT_FRAC, GUARD);
    localparam int ACC_INT  = acc_int_f(IN_INT, OUT_INT, N_TERMS);
    localparam int ACC_W    = 1 + ACC_INT + ACC_FRAC;
    localparam int RW       = ACC_FRAC + 2;
    localparam int PW       = ACC_W + IN_W + RW;
    localparam int SHIFT    = IN_FRAC + ACC_FRAC;
    localparam int KW       = $clog2(N_TERMS);

    localparam logic [KW-1:0] K_LAST = KW'(N_TERMS - 1);
    localparam logic signed [IN_W-1:0] SAT_CODE = IN_W'(SAT_X_CODE);
    localparam logic signed [ACC_W-1:0] ONE =
        {{(ACC_W-ACC_FRAC-1){1'b0}}, 1'b1, {ACC_FRAC{1'b0}}};

    state_e                   state_q, state_d;
    logic signed [IN_W-1:0]   x_q, x_d;
    logic signed [ACC_W-1:0]  term_q, term_d;
    logic signed [ACC_W-1:0]  sum_q, sum_d;
    logic [KW-1:0]            k_q, k_d;
    logic [OUT_W-1:0]         out_y_q, out_y_d;
    logic                     out_sat_q, out_sat_d;
    logic                     out_valid_q, out_valid_d;

    logic signed [RW-1:0]     recip_tab [N_TERMS];
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  term_nx;
    logic                     iter_end;
    logic [OUT_W-1:0]         rs_y;
    logic                     rs_sat;

    for (genvar g = 0; g < N_TERMS; g++) begin : g_recip
        assign recip_tab[g] = RW'(recip_f(g, ACC_FRAC));
    end

    // Arithmetic shift of the full product floors toward -inf.
    assign prod    = PW'(term_q) * PW'(x_q) * PW'(recip_tab[k_q]);
    assign term_nx = ACC_W'(prod >>> SHIFT);

`ifdef FIXED_EXP_EARLY_EXIT_EN
    assign iter_end = (k_q == K_LAST) || (term_nx == '0);
`else
    assign iter_end = (k_q == K_LAST);
`endif

    fixed_exp_round_sat #(
        .ACC_W (ACC_W),
        .GUARD (GUARD),
        .OUT_W (OUT_W)
    ) u_round_sat (
        .sum_i (sum_q),
        .y_o   (rs_y),
        .sat_o (rs_sat)
    );

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        term_d      = term_q;
        sum_d       = sum_q;
        k_d         = k_q;
        out_y_d     = out_y_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d = in_x;
                    if ($signed(in_x) >= SAT_CODE) begin
                        state_d = S_SAT;
                    end else begin
                        term_d  = ONE;
                        sum_d   = ONE;
                        k_d     = KW'(1);
                        state_d = S_ITER;
                    end
                end
            end
            S_ITER: begin
                term_d = term_nx;
                sum_d  = sum_q + term_nx;
                k_d    = k_q + KW'(1);
                if (iter_end) state_d = S_DONE;
            end
            S_SAT: begin
                if (!out_valid_q) begin
                    out_y_d     = '1;
                    out_sat_d   = 1'b1;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_DONE: begin
                if (!out_valid_q) begin
                    out_y_d     = rs_y;
                    out_sat_d   = rs_sat;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            term_q      <= '0;
            sum_q       <= '0;
            k_q         <= '0;
            out_y_q     <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            term_q      <= term_d;
            sum_q       <= sum_d;
            k_q         <= k_d;
            out_y_q     <= out_y_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fixed_exp_seq.sv
// tb_fixed_exp_seq: directed and random checks of fixed_exp_seq against
// a plain-arithmetic Taylor-series reference.
module tb_fixed_exp_seq;

    localparam int N     = 20;
    localparam int AF    = 13;
    localparam int IF    = 7;
    localparam int G     = 8;
    localparam int OMAX  = 1023;
    localparam int SATX  = 444;

    logic       clk;
    logic       RESET_N;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_x;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_y;
    logic       out_sat;

    int n_chk;
    int n_fail;

    fixed_exp_seq dut (
        .CLOCK_50  (clk),
        .RESET_N   (RESET_N),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // exp(x) as the series sum of x^k/k!, each term floored to AF bits.
    function automatic void model(input int x, output int y, output int s,
                                  output int lat);
        longint term;
        longint sum;
        longint r;
        y   = 0;
        s   = 0;
        lat = N;
        if (x >= SATX) begin
            y   = OMAX;
            s   = 1;
            lat = 1;
            return;
        end
        term = longint'(1) << AF;
        sum  = term;
        for (int k = 1; k < N; k++) begin
            r    = ((longint'(1) << AF) + k / 2) / k;
            term = (term * x * r) >>> (IF + AF);
            sum  = sum + term;
`ifdef FIXED_EXP_EARLY_EXIT_EN
            if (term == 0 && lat == N) lat = k + 1;
`endif
        end
        if (sum < 0) begin
            y = 0;
        end else begin
            r = (sum + (longint'(1) << (G - 1))) >>> G;
            if (r > OMAX) begin
                y = OMAX;
                s = 1;
            end else begin
                y = int'(r);
            end
        end
    endfunction

    task automatic launch(input logic [9:0] x);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        in_valid = 1'b1;
        in_x     = x;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic do_op(input string tag, input logic [9:0] x,
                         output int y_got);
        int lat, ey, es, el, xi;
        xi = int'($signed(x));
        model(xi, ey, es, el);
        launch(x);
        wait_valid(lat);
        y_got = int'(out_y);
        chk({tag, "_y"}, 64'(out_y), 64'(ey));
        chk({tag, "_sat"}, 64'(out_sat), 64'(es));
        chk({tag, "_lat"}, 64'(lat), 64'(el));
        take();
        chk({tag, "_drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int y, y0, lat, seen;
        logic [9:0] xr;
        n_chk     = 0;
        n_fail    = 0;
        RESET_N   = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        out_ready = 1'b1;
        #3;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_y", 64'(out_y), 64'd0);
        chk("rst_out_sat", 64'(out_sat), 64'd0);
        @(negedge clk);
        RESET_N = 1'b1;
        @(posedge clk); #1;

        do_op("one", 10'd128, y);
        chk("one_spec", 64'(y), 64'd87);
        do_op("zero", 10'd0, y);
        chk("zero_spec", 64'(y), 64'd32);
        do_op("m4", 10'h200, y);
        chk("m4_spec", 64'(y), 64'd1);
        do_op("x443", 10'd443, y);
        chk("x443_spec", 64'(y), 64'd1019);
        do_op("x444", 10'd444, y);
        chk("x444_spec", 64'(y), 64'd1023);
        do_op("x511", 10'd511, y);
        chk("x511_spec", 64'(y), 64'd1023);

`ifdef FIXED_EXP_EARLY_EXIT_EN
        launch(10'h200);
        wait_valid(lat);
        chk("ee_m4_y", 64'(out_y), 64'd1);
        chk("ee_m4_fast", 64'(lat < N), 64'd1);
        take();
`endif

        // Back-pressure: result must hold and new requests be ignored.
        out_ready = 1'b0;
        launch(10'h300);
        wait_valid(lat);
        y0 = int'(out_y);
        model(-256, y, seen, lat);
        chk("bp_y", 64'(y0), 64'(y));
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_x     = 10'd128;
            @(posedge clk); #1;
            chk("bp_stable", 64'(out_y), 64'(y0));
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        take();
        chk("bp_release", 64'(out_valid), 64'd0);
        chk("bp_idle", 64'(in_ready), 64'd1);
        do_op("bp_next", 10'd0, y);

        // Reset part-way through the series.
        launch(10'd128);
        repeat (9) begin
            @(posedge clk); #1;
        end
        RESET_N = 1'b0;
        #1;
        chk("mid_in_ready", 64'(in_ready), 64'd1);
        chk("mid_out_valid", 64'(out_valid), 64'd0);
        chk("mid_out_y", 64'(out_y), 64'd0);
        chk("mid_out_sat", 64'(out_sat), 64'd0);
        @(negedge clk);
        RESET_N = 1'b1;
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("mid_no_valid", 64'(seen), 64'd0);
        do_op("post_rst", 10'd128, y);
        chk("post_rst_spec", 64'(y), 64'd87);

        for (int i = 0; i < 40; i++) begin
            xr = 10'($urandom_range(0, 1023));
            do_op("rand", xr, y);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
